// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: two one-entry holds
// (A = execute result, B = load data) drained oldest-first into registered D_En/D_Addr/D.
module regfile_wb_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          D_En,
  output logic [AW-1:0] D_Addr,
  output logic [DW-1:0] D,
  input  logic [AW-1:0] S_Addr,
  input  logic [AW-1:0] T_Addr,
  output logic          s_pending,
  output logic          t_pending,
  output logic [4:0]    dbg_state
);

  // Handshake: a transfer happens on a rising edge where x_valid & x_ready are both 1;
  // x_ready depends only on registered state, never on x_valid.

  typedef enum logic [1:0] {
    AGE_SAME    = 2'b00,
    AGE_A_OLDER = 2'b01,
    AGE_B_OLDER = 2'b10
  } age_e;

  logic          hold_a_full_q, hold_a_full_d;
  logic          hold_b_full_q, hold_b_full_d;
  logic [AW-1:0] hold_a_addr_q, hold_a_addr_d;
  logic [AW-1:0] hold_b_addr_q, hold_b_addr_d;
  logic [DW-1:0] hold_a_data_q, hold_a_data_d;
  logic [DW-1:0] hold_b_data_q, hold_b_data_d;
  age_e          age_q, age_d;
  logic          rr_q, rr_d;
  logic          d_en_q, d_en_d;
  logic [AW-1:0] d_addr_q, d_addr_d;
  logic [DW-1:0] d_data_q, d_data_d;

  logic grant_a, grant_b, tie;
  logic acc_a, acc_b;

  // rr_q: 0 points at A, 1 at B; a same-age tie goes to the side not pointed at.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    tie     = 1'b0;
    unique case ({hold_a_full_q, hold_b_full_q})
      2'b10: grant_a = 1'b1;
      2'b01: grant_b = 1'b1;
      2'b11: begin
        if (age_q == AGE_A_OLDER) begin
          grant_a = 1'b1;
        end else if (age_q == AGE_B_OLDER) begin
          grant_b = 1'b1;
        end else begin
          tie = 1'b1;
          if ((FIXED_PRIO != 0) || rr_q) begin
            grant_a = 1'b1;
          end else begin
            grant_b = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign a_ready = ~hold_a_full_q | grant_a;
  assign b_ready = ~hold_b_full_q | grant_b;
  assign acc_a   = a_valid & a_ready;
  assign acc_b   = b_valid & b_ready;

  always_comb begin
    hold_a_full_d = hold_a_full_q;
    hold_b_full_d = hold_b_full_q;
    hold_a_addr_d = hold_a_addr_q;
    hold_b_addr_d = hold_b_addr_q;
    hold_a_data_d = hold_a_data_q;
    hold_b_data_d = hold_b_data_q;
    age_d         = age_q;
    rr_d          = rr_q;
    d_en_d        = 1'b0;
    d_addr_d      = d_addr_q;
    d_data_d      = d_data_q;

    if (acc_a) begin
      hold_a_full_d = 1'b1;
      hold_a_addr_d = a_addr;
      hold_a_data_d = a_data;
    end else if (grant_a) begin
      hold_a_full_d = 1'b0;
    end

    if (acc_b) begin
      hold_b_full_d = 1'b1;
      hold_b_addr_d = b_addr;
      hold_b_data_d = b_data;
    end else if (grant_b) begin
      hold_b_full_d = 1'b0;
    end

    // The hold that was not refilled on this edge is the older one.
    if (hold_a_full_d && hold_b_full_d) begin
      if (acc_a && acc_b) begin
        age_d = AGE_SAME;
      end else if (acc_a) begin
        age_d = AGE_B_OLDER;
      end else if (acc_b) begin
        age_d = AGE_A_OLDER;
      end
    end else begin
      age_d = AGE_SAME;
    end

    if (tie) begin
      rr_d = ~rr_q;
    end

    // r0 is hardwired: its writes drain from the hold but never reach the port.
    if (grant_a && (hold_a_addr_q != '0)) begin
      d_en_d   = 1'b1;
      d_addr_d = hold_a_addr_q;
      d_data_d = hold_a_data_q;
    end else if (grant_b && (hold_b_addr_q != '0)) begin
      d_en_d   = 1'b1;
      d_addr_d = hold_b_addr_q;
      d_data_d = hold_b_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_a_full_q <= 1'b0;
      hold_b_full_q <= 1'b0;
      hold_a_addr_q <= '0;
      hold_b_addr_q <= '0;
      hold_a_data_q <= '0;
      hold_b_data_q <= '0;
      age_q         <= AGE_SAME;
      rr_q          <= 1'b0;
      d_en_q        <= 1'b0;
      d_addr_q      <= '0;
      d_data_q      <= '0;
    end else begin
      hold_a_full_q <= hold_a_full_d;
      hold_b_full_q <= hold_b_full_d;
      hold_a_addr_q <= hold_a_addr_d;
      hold_b_addr_q <= hold_b_addr_d;
      hold_a_data_q <= hold_a_data_d;
      hold_b_data_q <= hold_b_data_d;
      age_q         <= age_d;
      rr_q          <= rr_d;
      d_en_q        <= d_en_d;
      d_addr_q      <= d_addr_d;
      d_data_q      <= d_data_d;
    end
  end

  assign D_En   = d_en_q;
  assign D_Addr = d_addr_q;
  assign D      = d_data_q;

  // Pending covers writes still held plus the one being committed this cycle.
  assign s_pending = (S_Addr != '0) &&
                     ((hold_a_full_q && (hold_a_addr_q == S_Addr)) ||
                      (hold_b_full_q && (hold_b_addr_q == S_Addr)) ||
                      (d_en_q && (d_addr_q == S_Addr)));
  assign t_pending = (T_Addr != '0) &&
                     ((hold_a_full_q && (hold_a_addr_q == T_Addr)) ||
                      (hold_b_full_q && (hold_b_addr_q == T_Addr)) ||
                      (d_en_q && (d_addr_q == T_Addr)));

  assign dbg_state = {hold_a_full_q, hold_b_full_q, age_q, rr_q};

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random single-requester
// streams, with every committed write checked against an expected-write queue.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          D_En;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D;
  logic [AW-1:0] S_Addr, T_Addr;
  logic          s_pending, t_pending;
  logic [4:0]    dbg_state;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    rf_shadow [32];
  int n_cmp;
  int n_err;

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .D_En(D_En), .D_Addr(D_Addr), .D(D),
    .S_Addr(S_Addr), .T_Addr(T_Addr),
    .s_pending(s_pending), .t_pending(t_pending),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset && D_En) begin
      check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check_eq("wr_addr_data", 64'({D_Addr, D}), 64'(exp_q.pop_front()));
      end
      rf_shadow[D_Addr] = D;
    end
  end

  // ---------------- drivers ----------------
  task automatic push_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int waited;
    a_valid = 1'b1;
    a_addr  = addr;
    a_data  = data;
    waited  = 0;
    while (!a_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_eq("a_ready_wait", 64'(a_ready), 64'd1);
    if (addr != '0) exp_q.push_back({addr, data});
    tick();
  endtask

  task automatic push_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int waited;
    b_valid = 1'b1;
    b_addr  = addr;
    b_data  = data;
    waited  = 0;
    while (!b_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_eq("b_ready_wait", 64'(b_ready), 64'd1);
    if (addr != '0) exp_q.push_back({addr, data});
    tick();
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) rf_shadow[i] = '0;
    reset   = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr  = '0;   b_addr  = '0;
    a_data  = '0;   b_data  = '0;
    S_Addr  = '0;   T_Addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_d_en", 64'(D_En), 64'd0);
    check_eq("rst_d_addr", 64'(D_Addr), 64'd0);
    check_eq("rst_d", 64'(D), 64'd0);
    check_eq("rst_dbg", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    tick();
    check_eq("rst_a_ready", 64'(a_ready), 64'd1);
    check_eq("rst_b_ready", 64'(b_ready), 64'd1);

    // single write with latency check
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    a_valid = 1'b0;
    check_eq("single_d_en_lat1", 64'(D_En), 64'd0);
    check_eq("single_a_ready", 64'(a_ready), 64'd1);
    tick();
    check_eq("single_d_en_lat2", 64'(D_En), 64'd1);
    check_eq("single_d_addr", 64'(D_Addr), 64'd5);
    check_eq("single_d", 64'(D), 64'hDEADBEEF);
    idle(2);

    // same-edge contention: rr at A, so B goes first
    check_eq("cont_rr_before", 64'(dbg_state[0]), 64'd0);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    exp_q.push_back({5'd4, 32'h22});
    exp_q.push_back({5'd3, 32'h11});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check_eq("cont_b_ready", 64'(b_ready), 64'd1);
    check_eq("cont_a_ready", 64'(a_ready), 64'd0);
    tick();
    check_eq("cont_rr_after", 64'(dbg_state[0]), 64'd1);
    check_eq("cont_a_ready2", 64'(a_ready), 64'd1);
    idle(3);

    // RAW hazard flags
    S_Addr = 5'd9; T_Addr = 5'd10;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    check_eq("haz_s_pre", 64'(s_pending), 64'd0);
    exp_q.push_back({5'd9, 32'h99});
    tick();
    a_valid = 1'b0;
    check_eq("haz_s_held", 64'(s_pending), 64'd1);
    check_eq("haz_t_held", 64'(t_pending), 64'd0);
    tick();
    check_eq("haz_s_commit", 64'(s_pending), 64'd1);
    check_eq("haz_d_en", 64'(D_En), 64'd1);
    tick();
    check_eq("haz_s_clear", 64'(s_pending), 64'd0);
    idle(1);

    // zero register write is consumed without a port write
    S_Addr = 5'd0; T_Addr = 5'd0;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    tick();
    b_valid = 1'b0;
    check_eq("zero_s_pending", 64'(s_pending), 64'd0);
    tick();
    check_eq("zero_d_en", 64'(D_En), 64'd0);
    check_eq("zero_b_ready", 64'(b_ready), 64'd1);
    idle(2);

    // ordering: older B entry blocks A, then r7 written AA before BB
    check_eq("ord_rr_before", 64'(dbg_state[0]), 64'd1);
    a_valid = 1'b1; a_addr = 5'd1;  a_data = 32'h101;
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h55;
    exp_q.push_back({5'd1, 32'h101});
    exp_q.push_back({5'd12, 32'h55});
    exp_q.push_back({5'd7, 32'hAA});
    exp_q.push_back({5'd7, 32'hBB});
    tick();
    b_valid = 1'b0;
    a_addr = 5'd7; a_data = 32'hAA;
    check_eq("ord_a_ready_tie", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    check_eq("ord_a_blocked", 64'(a_ready), 64'd0);
    check_eq("ord_b_ready", 64'(b_ready), 64'd1);
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBB;
    tick();
    b_valid = 1'b0;
    idle(4);
    check_eq("ord_r7_final", 64'(rf_shadow[7]), 64'hBB);

    // reset mid-flight: both holds full, one write in progress
    a_valid = 1'b1; a_addr = 5'd21; a_data = 32'h2121;
    b_valid = 1'b1; b_addr = 5'd22; b_data = 32'h2222;
    exp_q.push_back({5'd22, 32'h2222});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    #5;
    check_eq("rstmid_d_en_pre", 64'(D_En), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("rstmid_d_en", 64'(D_En), 64'd0);
    check_eq("rstmid_dbg", 64'(dbg_state), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rstmid_a_ready", 64'(a_ready), 64'd1);
    check_eq("rstmid_b_ready", 64'(b_ready), 64'd1);
    idle(4);

    // random back-to-back streams, one requester at a time
    for (int i = 0; i < 10; i++) push_a(5'($urandom_range(0, 31)), $urandom);
    idle(3);
    for (int i = 0; i < 10; i++) push_b(5'($urandom_range(0, 31)), $urandom);
    idle(3);

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU/execute result) and B (load data from memory).
- Each requester has a one-entry holding register behind a valid/ready handshake.
- An arbiter drains the holding registers into registered D_En/D_Addr/D outputs, one write per cycle.
- Also drives per-read-address pending flags so decode can stall on RAW hazards against writes not yet committed.

Parameters:
- DW, 32, data width
- AW, 5, register address width
- FIXED_PRIO, 0, 0 = round-robin on a same-age tie; 1 = A always wins a same-age tie

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a write
- a_addr  in  AW  A destination register
- a_data  in  DW  A write data
- a_ready  out  1  A holding register can accept this cycle
- b_valid  in  1  requester B has a write
- b_addr  in  AW  B destination register
- b_data  in  DW  B write data
- b_ready  out  1  B holding register can accept this cycle
- D_En  out  1  register file write enable (registered)
- D_Addr  out  AW  register file write address (registered)
- D  out  DW  register file write data (registered)
- S_Addr  in  AW  decode source address S
- T_Addr  in  AW  decode source address T
- s_pending  out  1  S_Addr has an uncommitted write
- t_pending  out  1  T_Addr has an uncommitted write

Behaviour:
- Reset (reset=0, asynchronous):
  - hold_a_full = hold_b_full = 0; age bit = 0; rr pointer = A.
  - D_En = 0, D_Addr = 0, D = 0.
  - A reset mid-operation discards held writes; no write is issued afterwards.
- Accept:
  - x_ready = ~hold_x_full | grant_x (combinational from registered state).
  - On valid & ready at the edge, hold_x captures addr/data and is marked full.
  - Back-to-back accepts give one write per cycle per requester when uncontended.
- Age:
  - When both holds are full, the one captured on the earlier edge is older.
  - Captured on the same edge: treated as same age.
- Grant each cycle (combinational):
  - Only one hold full: it is granted.
  - Both full, different age: older wins (guarantees program order to the same register).
  - Both full, same age: FIXED_PRIO=1 gives A; FIXED_PRIO=0 grants the requester opposite the rr pointer. The pointer toggles only on same-age ties.
  - Granted hold clears at the next edge, unless it is simultaneously refilled.
- Output register, at the edge following grant:
  - D_En = 1, D_Addr = hold addr, D = hold data.
  - With no grant: D_En = 0, and D_Addr/D hold their previous values.
- Address 0:
  - A granted entry with addr 0 is consumed normally but produces D_En = 0.
- Latency: a_valid accepted at edge N → D_En high in the cycle after edge N+1 (write lands at edge N+2), if uncontended.
- Pending flags:
  - x_pending = (Addr != 0) & (Addr matches any full hold, or D_En & D_Addr == Addr).
  - Purely combinational; does not include the current-cycle input.
- Simultaneous events:
  - Grant and refill of the same hold on one edge: the new entry is stored.
  - A losing requester keeps its hold, with ready = 0, until granted.

Test Plan:
- Single write: A sends addr 5, data 0xDEADBEEF → D_En=1, D_Addr=5, D=0xDEADBEEF two edges after accept; a_ready stays 1.
- Contention, same edge, FIXED_PRIO=0: A(3,0x11) and B(4,0x22) → first write B(4,0x22), then A(3,0x11); rr pointer toggled; b_ready=1, a_ready=0 for one cycle.
- Ordering: A(7,0xAA) accepted at edge 1; B(7,0xBB) at edge 2 while A is blocked by a prior B entry → writes to r7 are 0xAA, then 0xBB; final r7 = 0xBB.
- Zero register: B(0,0xFFFFFFFF) → consumed; D_En stays 0; s_pending=0 with S_Addr=0.
- Hazard: A(9,x) held, S_Addr=9 → s_pending=1 until the cycle after D_En for r9; T_Addr=10 → t_pending=0.
- Reset mid-flight: both holds full, reset pulsed low asynchronously → D_En=0 immediately, a_ready=b_ready=1 after release, no stale write issued.
